inv_subbytes_iter: RTL and testbench
====================================

Name: inv_subbytes_iter

Overview:
- Iterative InvSubBytes stage for the AES decryption datapath, placed directly downstream of the InvShiftRows stage.
- Accepts a 128-bit state through a valid/ready handshake and substitutes every byte through a shared bank of inverse S-box lanes, LANES bytes per cycle.
- Presents the substituted state on a held output register for the next stage (AddRoundKey/InvMixColumns).
- Trades latency for area against a 16-lane combinational implementation.

Parameters:
- LANES, 4, inverse S-box instances used per cycle; legal values 1, 2, 4, 8, 16; PASSES = 16/LANES.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_state is valid.
- in_ready  out  1  block can accept a state.
- in_state  in  [0:127]  state from InvShiftRows; byte k = bits [8k:8k+7]; byte 0 = bits [0:7].
- abort  in  1  synchronous cancel of the operation in flight.
- out_valid  out  1  out_state holds a completed result.
- out_ready  in  1  downstream accepts out_state.
- out_state  out  [0:127]  InvSubBytes(in_state); same byte ordering.
- busy  out  1  high while in the PROC state.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, pass counter=0, working register=0, out_state=0.
  - in_ready=1, out_valid=0, busy=0.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: latch in_state into the working register, pass counter=0, go to PROC.
  - PROC:
    - in_ready=0, busy=1.
    - Each cycle, replace bytes [LANES*p .. LANES*p+LANES-1] of the working register with InvSbox(byte), where p is the pass counter; then increment p.
    - On the cycle p==PASSES-1: write the completed result into out_state, set out_valid=1, go to DONE.
  - DONE:
    - out_valid=1, in_ready=0.
    - out_state is held stable while out_ready=0.
    - On out_ready=1: out_valid=0 next cycle and go to IDLE.
    - No same-cycle re-accept; in_ready rises the cycle after the handoff.
- Latency: accept at edge N; out_valid high after edge N+PASSES (LANES=4: 4 cycles; LANES=16: 1 cycle; LANES=1: 16 cycles).
- Throughput: one state per PASSES+2 cycles with out_ready held high.
- InvSbox: the FIPS-197 inverse S-box, exact for all 256 inputs. A ROM table or GF(2^8) inverse with the inverse affine transform are both acceptable. Purely combinational per lane; no extra pipeline stage inside a lane.
- Handshake rules:
  - in_state is sampled only on the accept edge; later changes have no effect.
  - in_valid while in_ready=0 is ignored; no state is queued.
  - out_valid, once asserted, stays high until out_ready is seen.
- abort:
  - In PROC: go to IDLE next cycle, discard the working register, leave out_valid=0.
  - In DONE: drop out_valid and go to IDLE. Abort has priority over out_ready.
  - In IDLE: abort blocks an accept in the same cycle.
- Mid-operation reset: immediate return to reset values; the partial result is never emitted.
- Counter width is clog2(PASSES) with a minimum of 1 bit. It never wraps past PASSES-1 in PROC.

Test Plan:
1. After reset, in_state=128'h0 with in_valid pulsed -> out_valid after 4 cycles (LANES=4); out_state = 128'h52525252525252525252525252525252.
2. in_state bytes 63,7C,ED,FF repeated four times (128'h637CEDFF637CEDFF637CEDFF637CEDFF) -> out_state = 128'h0001537D0001537D0001537D0001537D.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_state and out_valid stable; in_ready=0 throughout; a new in_valid is not accepted until the cycle after out_ready=1.
4. abort asserted on the second PROC cycle -> IDLE next cycle, out_valid never asserted; the following state 128'h0 completes normally with value 52...52.
5. rst asserted asynchronously mid-PROC, then released -> all outputs at reset values immediately; a following transaction completes correctly.
6. Parameter sweep with LANES=1, 2, 8 and 16 -> latency of 16, 8, 2 and 1 cycles; exhaustive check of all 256 byte values (16 states of 16 distinct bytes) against a reference inverse S-box model.

Source files
------------

// File: rtl/inv_subbytes_iter_if.sv
// Handshake bundle between the InvShiftRows stage, the iterative InvSubBytes
// stage and the downstream AddRoundKey/InvMixColumns consumer.
interface inv_subbytes_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;
  logic         busy;

  modport slave (
    input  in_valid, in_state, abort, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, abort, out_ready,
    input  in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/inv_subbytes_iter.sv
// Iterative InvSubBytes: substitutes LANES bytes of the AES state per cycle
// through a shared bank of inverse S-box lanes, then holds the result for handoff.
module inv_subbytes_iter #(
  parameter int LANES = 4
) (
  input logic           clk,
  input logic           rst,
  inv_subbytes_iter_if.slave bus
);

  localparam int PASSES = 16 / LANES;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] pass_cnt;
  logic [0:127]     work, work_next, result;
  logic             accept, last_pass;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 via an addition chain; 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  // Inverse affine transform (rotations by 1, 3, 6 plus 0x05), then field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  assign accept    = (state == IDLE) && bus.in_valid && !bus.abort;
  assign last_pass = (pass_cnt == LAST);

  always_comb begin : lane_bank
    logic [6:0] base;
    work_next = work;
    base      = '0;
    for (int l = 0; l < LANES; l++) begin
      base = 7'((int'(pass_cnt) * LANES + l) * 8);
      work_next[base +: 8] = inv_sbox(work[base +: 8]);
    end
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) state_next = PROC;
      end
      PROC: begin
        bus.busy = 1'b1;
        if (bus.abort)     state_next = IDLE;
        else if (last_pass) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.abort || bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // An aborted pass clears the working register so no partial data lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work     <= '0;
      pass_cnt <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work     <= bus.in_state;
            pass_cnt <= '0;
          end
        end
        PROC: begin
          if (bus.abort) begin
            work     <= '0;
            pass_cnt <= '0;
          end else begin
            work     <= work_next;
            pass_cnt <= last_pass ? '0 : pass_cnt + CNT_W'(1);
            if (last_pass) result <= work_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_state = result;

endmodule

// File: tb/tb_inv_subbytes_iter.sv
// Self-checking bench for inv_subbytes_iter: LANES=4 instance for protocol tests
// plus LANES=1/2/8/16 instances for latency and exhaustive S-box coverage.
module tb_inv_subbytes_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_subbytes_iter_if bus();
  inv_subbytes_iter #(.LANES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam int NSW = 4;
  logic               sw_valid, sw_ready, sw_abort;
  logic [0:127]       sw_state;
  logic [NSW-1:0]     sw_out_valid, sw_in_ready;
  logic [0:127]       sw_out_state [NSW];

  genvar g;
  generate
    for (g = 0; g < NSW; g++) begin : sweep
      localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      inv_subbytes_iter_if sbus();
      assign sbus.in_valid    = sw_valid;
      assign sbus.in_state    = sw_state;
      assign sbus.abort       = sw_abort;
      assign sbus.out_ready   = sw_ready;
      assign sw_out_valid[g]  = sbus.out_valid;
      assign sw_in_ready[g]   = sbus.in_ready;
      assign sw_out_state[g]  = sbus.out_state;
      inv_subbytes_iter #(.LANES(L)) u (.clk(clk), .rst(rst), .bus(sbus));
    end
  endgenerate

  int total = 0;
  int bad   = 0;
  logic [7:0] inv_tab [256];

  // Reference: forward S-box from a brute-force field inverse, inverted as a permutation.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_tables();
    logic [7:0] x, y, inv, fwd;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++) begin
        y = 8'(j);
        if (ref_mul(x, y) == 8'h01) inv = y;
      end
      fwd = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tab[fwd] = x;
    end
  endtask

  function automatic logic [0:127] ref_sub(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = s[0:7];
      r = {r[8:127], inv_tab[b]};
      s = s << 8;
    end
    return r;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accept and waits (bounded) for out_valid; lat=-1 on timeout.
  task automatic run_one(input logic [0:127] s, output int lat, output logic [0:127] res);
    bus.in_state = s;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_state = rnd128();
    lat = -1;
    res = '0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.out_valid) begin
        lat = c;
        res = bus.out_state;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.out_state !== 128'h0) begin bad++; $display("[TB] FAIL reset_out_state got=%h want=0", bus.out_state); end
    total++; if (sw_in_ready !== 4'hF) begin bad++; $display("[TB] FAIL reset_sweep_in_ready got=%b want=1111", sw_in_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_known_vectors();
    int lat;
    logic [0:127] res;
    bus.out_ready = 1'b1;
    run_one(128'h0, lat, res);
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL zero_latency got=%0d want=4", lat); end
    total++; if (res !== 128'h52525252525252525252525252525252) begin bad++; $display("[TB] FAIL zero_value got=%h want=5252...52", res); end
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL handoff_idle got out_valid=%0b in_ready=%0b want 0/1", bus.out_valid, bus.in_ready); end
    run_one(128'h637CEDFF637CEDFF637CEDFF637CEDFF, lat, res);
    total++; if (res !== 128'h0001537D0001537D0001537D0001537D) begin bad++; $display("[TB] FAIL pattern_value got=%h want=0001537D...", res); end
    tick();
  endtask

  task automatic test_random();
    int lat;
    logic [0:127] s, res;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s = rnd128();
      run_one(s, lat, res);
      total++; if (lat !== 4) begin bad++; $display("[TB] FAIL random_latency[%0d] got=%0d want=4", i, lat); end
      total++; if (res !== ref_sub(s)) begin bad++; $display("[TB] FAIL random_value[%0d] got=%h want=%h", i, res, ref_sub(s)); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [0:127] s1, s2, res;
    s1 = rnd128();
    s2 = rnd128();
    bus.out_ready = 1'b0;
    run_one(s1, lat, res);
    total++; if (res !== ref_sub(s1)) begin bad++; $display("[TB] FAIL bp_value got=%h want=%h", res, ref_sub(s1)); end
    bus.in_state = s2;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_state !== ref_sub(s1)) begin
        bad++;
        $display("[TB] FAIL bp_hold[%0d] got valid=%0b ready=%0b state=%h want 1/0/%h", c, bus.out_valid, bus.in_ready, bus.out_state, ref_sub(s1));
      end
    end
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_handoff got valid=%0b ready=%0b busy=%0b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy); end
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL bp_reaccept got busy=%0b want=1", bus.busy); end
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.out_valid) begin lat = c; res = bus.out_state; break; end
    end
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL bp_second_latency got=%0d want=4", lat); end
    total++; if (res !== ref_sub(s2)) begin bad++; $display("[TB] FAIL bp_second_value got=%h want=%h", res, ref_sub(s2)); end
    tick();
  endtask

  task automatic test_abort();
    int lat;
    logic seen;
    logic [0:127] res;
    bus.out_ready = 1'b1;
    bus.in_state = 128'h0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_proc got ready=%0b busy=%0b valid=%0b want 1/0/0", bus.in_ready, bus.busy, bus.out_valid); end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_output got=%0b want=0", seen); end
    run_one(128'h0, lat, res);
    total++; if (lat !== 4 || res !== 128'h52525252525252525252525252525252) begin bad++; $display("[TB] FAIL abort_followup got lat=%0d val=%h want 4/5252...52", lat, res); end
    tick();
    bus.out_ready = 1'b0;
    run_one(rnd128(), lat, res);
    bus.abort = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.abort = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_done got valid=%0b ready=%0b want 0/1", bus.out_valid, bus.in_ready); end
    bus.in_state = rnd128();
    bus.in_valid = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_idle_block got busy=%0b ready=%0b want 0/1", bus.busy, bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    logic [0:127] s, res;
    bus.out_ready = 1'b1;
    bus.in_state = rnd128();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ctrl got ready=%0b busy=%0b valid=%0b want 1/0/0", bus.in_ready, bus.busy, bus.out_valid); end
    total++; if (bus.out_state !== 128'h0) begin bad++; $display("[TB] FAIL midrst_state got=%h want=0", bus.out_state); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL midrst_no_output got=%0b want=0", seen); end
    s = rnd128();
    run_one(s, lat, res);
    total++; if (lat !== 4 || res !== ref_sub(s)) begin bad++; $display("[TB] FAIL midrst_followup got lat=%0d val=%h want 4/%h", lat, res, ref_sub(s)); end
    tick();
  endtask

  task automatic test_back_to_back();
    int first, second;
    bus.out_ready = 1'b1;
    bus.in_state = rnd128();
    bus.in_valid = 1'b1;
    tick();
    first = -1;
    second = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.out_valid) begin
        if (first < 0) first = c;
        else begin second = c; break; end
      end
    end
    bus.in_valid = 1'b0;
    tick();
    total++; if (first !== 4) begin bad++; $display("[TB] FAIL b2b_first got=%0d want=4", first); end
    total++; if (second !== 10) begin bad++; $display("[TB] FAIL b2b_second got=%0d want=10", second); end
  endtask

  task automatic test_lane_sweep();
    int perm [256];
    int exp_lat [NSW];
    int lanes [NSW];
    int slat [NSW];
    logic [0:127] sres [NSW];
    logic [0:127] s;
    int j, tmp;
    exp_lat = '{16, 8, 2, 1};
    lanes   = '{1, 2, 8, 16};
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    sw_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      s = '0;
      for (int k = 0; k < 16; k++) s = {s[8:127], 8'(perm[16 * t + k])};
      total++; if (sw_in_ready !== 4'hF) begin bad++; $display("[TB] FAIL sweep_ready[%0d] got=%b want=1111", t, sw_in_ready); end
      sw_state = s;
      sw_valid = 1'b1;
      tick();
      sw_valid = 1'b0;
      for (int n = 0; n < NSW; n++) begin slat[n] = -1; sres[n] = '0; end
      for (int c = 1; c <= 20; c++) begin
        tick();
        for (int n = 0; n < NSW; n++) begin
          if (sw_out_valid[n] && slat[n] < 0) begin
            slat[n] = c;
            sres[n] = sw_out_state[n];
          end
        end
      end
      for (int n = 0; n < NSW; n++) begin
        total++; if (slat[n] !== exp_lat[n]) begin bad++; $display("[TB] FAIL sweep_latency lanes=%0d blk=%0d got=%0d want=%0d", lanes[n], t, slat[n], exp_lat[n]); end
        total++; if (sres[n] !== ref_sub(s)) begin bad++; $display("[TB] FAIL sweep_value lanes=%0d blk=%0d got=%h want=%h", lanes[n], t, sres[n], ref_sub(s)); end
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    sw_valid      = 1'b0;
    sw_ready      = 1'b1;
    sw_abort      = 1'b0;
    sw_state      = '0;
    build_tables();
    test_reset();
    test_known_vectors();
    test_random();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_lane_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
